// File: rtl/card_pkg.sv
// Shared types and helpers for the card shoe controller.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package card_pkg;

    localparam int NUM_RANKS               = 13;
    localparam int CARDS_PER_RANK_PER_DECK = 4;

    // 1=A, 2..10, 11=J, 12=Q, 13=K; 0 and 14..15 are not ranks
    typedef logic [3:0] rank_t;

    typedef enum logic [2:0] {
        IDLE,
        DRAW,
        SCAN,
        DELIVER,
        SHUFFLE
    } dealer_state_t;

    // Blackjack value of a rank: ace counts 11, faces count 10
    function automatic logic [3:0] rank_to_points(input rank_t r);
        if (r == 4'd1)
            return 4'd11;
        else if (r > 4'd10)
            return 4'd10;
        else
            return r;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter; the last-served pointer moves only on the update strobe.
// Latency: grant is combinational from req; pointer updates one cycle after the strobe.
// Backpressure: none; requesters hold req until served, grant simply follows req.
// Ports: clk/rst; req[1:0] (bit0 player, bit1 dealer); update strobe with served id;
//        grant[1:0] one-hot (or zero when nobody requests).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant
);

    // 1 = requester 1 (dealer) was served last, so requester 0 wins the next tie
    logic last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last <= 1'b1;
        else if (update)
            last <= served;
    end

    always_comb begin
        grant = req;
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/card_dealer.sv
// Finite card shoe: arbitrates player/dealer deal requests, draws a random rank, sequences reshuffles.
// Latency: ack two cycles after the grant edge on a first-draw hit; RETRY_MAX + rank extra cycles via scan.
// Backpressure: requests stall while the shoe is empty or a deal/shuffle is in progress.
// Ports: clk, rst (async, active high); rnd[3:0] random rank; shuffle_req, player_req, dealer_req levels;
//        player_ack/dealer_ack one-cycle pulses; card_rank/card_points held until next deal;
//        busy (not IDLE); shoe_empty; cards_left[CL_W-1:0].
// Build option: define AUTO_SHUFFLE_EN to refill automatically once cards_left < SHUFFLE_THRESHOLD.
module card_dealer
    import card_pkg::*;
#(
    parameter int  NUM_DECKS         = 1,
    parameter int  RETRY_MAX         = 16,
    parameter int  SHUFFLE_THRESHOLD = 12,
    localparam int CL_W              = $clog2(52 * NUM_DECKS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      rnd,
    input  logic            shuffle_req,
    input  logic            player_req,
    input  logic            dealer_req,
    output logic            player_ack,
    output logic            dealer_ack,
    output logic [3:0]      card_rank,
    output logic [3:0]      card_points,
    output logic            busy,
    output logic            shoe_empty,
    output logic [CL_W-1:0] cards_left
);

    localparam int CPR  = CARDS_PER_RANK_PER_DECK * NUM_DECKS;
    localparam int SHOE = NUM_RANKS * CPR;
    localparam int UW   = $clog2(CPR + 1);
    localparam int RW   = $clog2(RETRY_MAX + 1);
`ifdef AUTO_SHUFFLE_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif

    typedef logic [UW-1:0] cnt_t;

    dealer_state_t state, state_nxt;
    cnt_t          used [NUM_RANKS];   // cards of rank i+1 already dealt
    logic [RW-1:0] retry;
    rank_t         scan_idx;
    rank_t         shuf_idx;
    logic          grantee;            // 0 player, 1 dealer
    logic [1:0]    grant;
    rank_t         cand;
    cnt_t          cand_cnt;
    logic          cand_ok;
    logic          auto_low;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({dealer_req, player_req}),
        .update (state == DELIVER),
        .served (grantee),
        .grant  (grant)
    );

    // DRAW tests the random rank, SCAN walks ranks upward from 1
    assign cand = (state == SCAN) ? scan_idx : rnd;

    always_comb begin
        cand_cnt = '0;
        for (int i = 0; i < NUM_RANKS; i++)
            if (cand == rank_t'(i + 1))
                cand_cnt = used[i];
    end

    assign cand_ok    = (cand >= 4'd1) && (cand <= rank_t'(NUM_RANKS)) && (cand_cnt < cnt_t'(CPR));
    assign auto_low   = AUTO_EN && (cards_left < CL_W'(SHUFFLE_THRESHOLD));
    assign shoe_empty = (cards_left == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        player_ack = 1'b0;
        dealer_ack = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (shuffle_req || auto_low)
                    state_nxt = SHUFFLE;
                else if (cards_left == '0)
                    state_nxt = IDLE;
                else if (|grant)
                    state_nxt = DRAW;
            end
            DRAW: begin
                if (cand_ok)
                    state_nxt = DELIVER;
                else if (retry == RW'(RETRY_MAX - 1))
                    state_nxt = SCAN;
            end
            SCAN: begin
                // cards_left > 0 guarantees a hit before the index runs past 13
                if (cand_ok)
                    state_nxt = DELIVER;
            end
            DELIVER: begin
                state_nxt  = IDLE;
                player_ack = ~grantee;
                dealer_ack = grantee;
            end
            SHUFFLE: begin
                if (shuf_idx == rank_t'(NUM_RANKS))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grantee     <= 1'b0;
            retry       <= '0;
            scan_idx    <= 4'd1;
            shuf_idx    <= 4'd1;
            cards_left  <= CL_W'(SHOE);
            card_rank   <= '0;
            card_points <= '0;
            for (int i = 0; i < NUM_RANKS; i++)
                used[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    retry    <= '0;
                    scan_idx <= 4'd1;
                    shuf_idx <= 4'd1;
                    if (state_nxt == DRAW)
                        grantee <= grant[1];
                end
                DRAW, SCAN: begin
                    if (cand_ok) begin
                        for (int i = 0; i < NUM_RANKS; i++)
                            if (cand == rank_t'(i + 1))
                                used[i] <= used[i] + cnt_t'(1);
                        cards_left  <= cards_left - CL_W'(1);
                        card_rank   <= cand;
                        card_points <= rank_to_points(cand);
                    end else if (state == DRAW) begin
                        retry <= retry + RW'(1);
                    end else begin
                        scan_idx <= scan_idx + 4'd1;
                    end
                end
                SHUFFLE: begin
                    for (int i = 0; i < NUM_RANKS; i++)
                        if (shuf_idx == rank_t'(i + 1))
                            used[i] <= '0;
                    shuf_idx <= shuf_idx + 4'd1;
                    // the count is restored together with the return to IDLE
                    if (shuf_idx == rank_t'(NUM_RANKS))
                        cards_left <= CL_W'(SHOE);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a transaction-level shoe model and a per-cycle compare process.
module tb_card_dealer;

    localparam int RETRY_MAX = 16;
    localparam int THRESH    = 12;
    localparam int SHOE      = 52;
    localparam int CPR       = 4;
    localparam int CL_W      = 6;

    logic            clk = 1'b0;
    logic            rst;
    logic [3:0]      rnd;
    logic            shuffle_req, player_req, dealer_req;
    logic            player_ack, dealer_ack, busy, shoe_empty;
    logic [3:0]      card_rank, card_points;
    logic [CL_W-1:0] cards_left;

    card_dealer #(
        .NUM_DECKS         (1),
        .RETRY_MAX         (RETRY_MAX),
        .SHUFFLE_THRESHOLD (THRESH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rnd         (rnd),
        .shuffle_req (shuffle_req),
        .player_req  (player_req),
        .dealer_req  (dealer_req),
        .player_ack  (player_ack),
        .dealer_ack  (dealer_ack),
        .card_rank   (card_rank),
        .card_points (card_points),
        .busy        (busy),
        .shoe_empty  (shoe_empty),
        .cards_left  (cards_left)
    );

    always #5 clk = ~clk;

    // shoe model
    int   used_m [1:13];
    int   exp_cl;
    bit   last_dealer;
    int   last_rank, last_lat;
    bit   last_to_dealer;

    // expected outputs for the current cycle
    logic       e_pack, e_dack, e_busy;
    logic [3:0] e_rank, e_pts;
    bit         mon_en;

    int checks, errors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pts_of(input int r);
        if (r == 1) return 11;
        if (r >= 11) return 10;
        return r;
    endfunction

    // mode 0: constant v; mode 1: counts up from v through 1..13 each draw cycle
    function automatic int rnd_at(input int mode, input int v, input int i);
        if (mode == 0) return v;
        return ((v - 1 + i) % 13) + 1;
    endfunction

    task automatic model_reset();
        for (int j = 1; j <= 13; j++) used_m[j] = 0;
        exp_cl      = SHOE;
        last_dealer = 1'b1;
        e_pack = 0; e_dack = 0; e_busy = 0; e_rank = 0; e_pts = 0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("player_ack",  player_ack,  e_pack);
            chk("dealer_ack",  dealer_ack,  e_dack);
            chk("busy",        busy,        e_busy);
            chk("card_rank",   card_rank,   e_rank);
            chk("card_points", card_points, e_pts);
            chk("cards_left",  cards_left,  exp_cl);
            chk("shoe_empty",  shoe_empty,  (exp_cl == 0));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From an IDLE cycle: 13 busy cycles, then back in IDLE with a full shoe.
    task automatic do_shuffle(input bit by_req);
        if (by_req) shuffle_req = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            step();
            shuffle_req = 1'b0;
            e_busy = 1'b1;
        end
        step();
        for (int j = 1; j <= 13; j++) used_m[j] = 0;
        exp_cl = SHOE;
        e_busy = 1'b0;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after the ack.
    task automatic deal(input bit pr, input bit dr, input int mode, input int v);
        bit to_d;
        bit found;
        int r, lat;
        player_req = pr;
        dealer_req = dr;
`ifdef AUTO_SHUFFLE_EN
        if (exp_cl < THRESH) do_shuffle(1'b0);
`endif
        to_d  = (pr && dr) ? !last_dealer : dr;
        found = 0;
        r     = 0;
        lat   = 0;
        for (int i = 0; i < RETRY_MAX && !found; i++) begin
            r = rnd_at(mode, v, i);
            if (r >= 1 && r <= 13 && used_m[r] < CPR) begin
                found = 1;
                lat   = i + 1;
            end
        end
        for (int j = 1; j <= 13 && !found; j++) begin
            if (used_m[j] < CPR) begin
                found = 1;
                r     = j;
                lat   = RETRY_MAX + j;
            end
        end
        // a different value in the grant cycle exposes sampling one cycle early
        rnd    = 4'(rnd_at(mode, v, 1));
        e_busy = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            step();
            rnd    = 4'(rnd_at(mode, v, k - 1));
            e_busy = 1'b1;
        end
        step();
        used_m[r]++;
        exp_cl--;
        last_dealer    = to_d;
        last_to_dealer = to_d;
        last_rank      = r;
        last_lat       = lat;
        e_pack = !to_d;
        e_dack = to_d;
        e_rank = 4'(r);
        e_pts  = 4'(pts_of(r));
        step();
        e_pack = 1'b0;
        e_dack = 1'b0;
        e_busy = 1'b0;
    endtask

    task automatic idle(input int n);
        player_req = 1'b0;
        dealer_req = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        checks = 0; errors = 0; mon_en = 0;
        rst = 1'b1; shuffle_req = 1'b0; player_req = 1'b0; dealer_req = 1'b0; rnd = 4'd0;
        last_rank = 0; last_lat = 0; last_to_dealer = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1;
        step();
        rst = 1'b0;
        step();

        // single player deal, rnd constant 7
        deal(1, 0, 0, 7);
        chk("t1_rank_lit",   card_rank,   7);
        chk("t1_points_lit", card_points, 7);
        chk("t1_left_lit",   cards_left,  51);
        chk("t1_latency",    last_lat,    1);

        // both requesting: round robin after a player grant -> dealer, player, dealer
        deal(1, 1, 1, 3);
        chk("alt1_dealer", last_to_dealer, 1);
        deal(1, 1, 1, 5);
        chk("alt2_player", last_to_dealer, 0);
        deal(1, 1, 1, 9);
        chk("alt3_dealer", last_to_dealer, 1);
        chk("alt3_rank_lit", card_rank, 9);
        idle(2);

        // four aces, then the fifth request falls back to scanning
        for (int n = 0; n < 4; n++) deal(1, 0, 0, 1);
        chk("ace_points_lit", card_points, 11);
        deal(1, 0, 0, 1);
        chk("ace5_rank_lit", card_rank, 2);
        chk("ace5_latency",  last_lat,  RETRY_MAX + 2);

        // counting rnd starting at an exhausted rank: second draw cycle hits
        deal(0, 1, 1, 1);
        chk("cyc_latency", last_lat, 2);
        chk("cyc_rank_lit", card_rank, 2);

        // out-of-range rnd values never hit
        deal(1, 0, 0, 15);
        chk("r15_rank_lit", card_rank, 2);
        chk("r15_latency", last_lat, RETRY_MAX + 2);
        deal(0, 1, 0, 0);
        chk("r0_rank_lit", card_rank, 2);
        idle(3);

        // refill, then drain the whole shoe
        do_shuffle(1'b1);
        chk("refill_left_lit", cards_left, 52);
        for (int r = 1; r <= 13; r++)
            for (int n = 0; n < 4; n++)
                deal(1, 0, 0, r);
`ifndef AUTO_SHUFFLE_EN
        chk("drain_left_lit",  cards_left, 0);
        chk("drain_empty_lit", shoe_empty, 1);
        // request stalls on an empty shoe, then shuffle refills and serves it
        player_req = 1'b1;
        rnd = 4'd5;
        for (int k = 0; k < 20; k++) step();
        do_shuffle(1'b1);
        deal(1, 0, 0, 5);
        chk("served_rank_lit", card_rank, 5);
        chk("served_left_lit", cards_left, 51);
`endif
        idle(2);

        // reset in the middle of a draw
        player_req = 1'b1;
        rnd = 4'd0;
        step();
        e_busy = 1'b1;
        step();
        step();
        rst = 1'b1;
        model_reset();
        step();
        step();
        rst = 1'b0;
        player_req = 1'b0;
        step();
        chk("rst_left_lit", cards_left, 52);
        chk("rst_rank_lit", card_rank, 0);
        step();

        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
